// File: rtl/auth_challenge_initiator.sv
// Challenge-response initiator: streams an LFSR challenge, then checks the
// responder's keyed reply and reports pass / fail / timeout.
module auth_challenge_initiator #(
    parameter int N_BYTES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] key_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o
);

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [TMR_W-1:0] LAST_IDLE = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [31:0]        key_q, key_d;
    logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
    logic [IDX_W-1:0]   rx_idx_q, rx_idx_d;
    logic [TMR_W-1:0]   idle_q, idle_d;
    logic               mismatch_q, mismatch_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [7:0]         chal_q [N_BYTES];
    logic               tx_fire;
    logic [1:0]         key_sel;
    logic [7:0]         key_byte;
    logic [7:0]         mix;
    logic [7:0]         exp_byte;
    logic               byte_ok;

    assign tx_fire  = (state_q == S_SEND) && tx_ready_i;
    assign key_sel  = 2'(rx_idx_q);
    assign key_byte = key_q[{key_sel, 3'b000} +: 8];
    assign mix      = chal_q[rx_idx_q] ^ key_byte;
    assign exp_byte = {mix[4:0], mix[7:5]} + 8'(rx_idx_q);
    assign byte_ok  = (rx_data_i == exp_byte);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        key_d      = key_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        idle_d     = idle_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_SEND;
                    key_d      = key_i;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    mismatch_d = 1'b0;
                    tx_idx_d   = '0;
                    rx_idx_d   = '0;
                    idle_d     = '0;
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                        idle_d  = '0;
                    end
                end
            end
            S_WAIT: begin
                // A byte always wins over the idle limit in the same cycle.
                if (rx_valid_i) begin
                    mismatch_d = mismatch_q | !byte_ok;
                    rx_idx_d   = rx_idx_q + 1'b1;
                    idle_d     = '0;
                    if (rx_idx_q == LAST_IDX) begin
                        state_d   = S_DONE;
                        pass_d    = !mismatch_q && byte_ok;
                        timeout_d = 1'b0;
                    end
                end else if (idle_q == LAST_IDLE) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = (state_d == S_SEND) ? lfsr_d : 8'h00;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 8'hA5;
            key_q      <= '0;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            idle_q     <= '0;
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            key_q      <= key_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            idle_q     <= idle_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_fire) begin
            chal_q[tx_idx_q] <= lfsr_q;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_auth_challenge_initiator.sv
// Scoreboard bench: expected challenge bytes and results are queued when a
// transaction is launched and checked as the initiator produces them.
module tb_auth_challenge_initiator;

    localparam int N  = 4;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] key_i = '0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        busy_o, done_o, pass_o, timeout_o;

    always #5 clk = ~clk;

    auth_challenge_initiator #(.N_BYTES(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         txn_no = 0;
    logic [7:0] q_tx[$];
    logic [1:0] q_res[$];
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] resp[N];
    logic [1:0] mon_res;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] f_exp(input logic [7:0] c, input logic [31:0] k, input int i);
        logic [7:0] x;
        x = c ^ k[8*(i%4) +: 8];
        return {x[4:0], x[7:5]} + 8'(i);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid_o) begin
                if (q_tx.size() == 0)       check_eq("tx_unexpected", 32'(tx_valid_o), 32'd0);
                else if (tx_ready_i)        check_eq("tx_byte", 32'(tx_data_o), 32'(q_tx.pop_front()));
                else                        check_eq("tx_hold", 32'(tx_data_o), 32'(q_tx[0]));
            end else begin
                check_eq("tx_idle_zero", 32'(tx_data_o), 32'd0);
            end
            if (done_o) begin
                done_cnt++;
                if (q_res.size() == 0) begin
                    check_eq("done_unexpected", 32'(done_o), 32'd0);
                end else begin
                    mon_res = q_res.pop_front();
                    check_eq("pass", 32'(pass_o), 32'(mon_res[1]));
                    check_eq("timeout", 32'(timeout_o), 32'(mon_res[0]));
                    txn_no++;
                    $display("txn %0d: pass=%0b timeout=%0b (expected %0b %0b)",
                             txn_no, pass_o, timeout_o, mon_res[1], mon_res[0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check_eq("rst_tx_data", 32'(tx_data_o), 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_pass", 32'(pass_o), 32'd0);
        check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    endtask

    task automatic send_challenge(input logic [31:0] key, input bit toggle, input bit poke);
        int sent;
        bit ph;
        key_i   = key;
        start_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            q_tx.push_back(m_lfsr);
            resp[i] = f_exp(m_lfsr, key, i);
            m_lfsr  = lfsr_next(m_lfsr);
        end
        cyc();
        start_i = 1'b0;
        check_eq("start_busy", 32'(busy_o), 32'd1);
        check_eq("start_tx_valid", 32'(tx_valid_o), 32'd1);
        sent = 0;
        ph   = 1'b0;
        for (int c = 0; c < 200 && sent < N; c++) begin
            tx_ready_i = toggle ? ph : 1'b1;
            ph = !ph;
            if (poke) begin
                start_i    = 1'($urandom_range(0, 1));
                key_i      = $urandom;
                rx_valid_i = 1'b1;
                rx_data_i  = 8'($urandom);
            end
            if (tx_valid_o && tx_ready_i) sent++;
            cyc();
        end
        tx_ready_i = 1'b0;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        check_eq("tx_count", 32'(sent), 32'(N));
    endtask

    task automatic send_resp(input int first, input int last, input int corrupt, input int gap);
        for (int i = first; i <= last; i++) begin
            repeat (gap) cyc();
            rx_valid_i = 1'b1;
            rx_data_i  = resp[i] ^ ((i == corrupt) ? 8'h01 : 8'h00);
            cyc();
            rx_valid_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int exp_lat, input logic [1:0] exp_res);
        int lat;
        lat = 0;
        while (!done_o && lat < 400) begin
            cyc();
            lat++;
        end
        check_eq("done_latency", 32'(lat), 32'(exp_lat));
        cyc();
        check_eq("done_one_cycle", 32'(done_o), 32'd0);
        check_eq("busy_after_done", 32'(busy_o), 32'd0);
        cyc();
        check_eq("pass_held", 32'(pass_o), 32'(exp_res[1]));
        check_eq("timeout_held", 32'(timeout_o), 32'(exp_res[0]));
    endtask

    initial begin
        int d;
        repeat (3) cyc();
        check_reset();
        rst_n = 1'b1;
        cyc();
        // Response bytes while idle must be ignored.
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h2D;
        repeat (3) cyc();
        rx_valid_i = 1'b0;
        check_eq("idle_rx_busy", 32'(busy_o), 32'd0);

        // Correct response with key 0.
        q_res.push_back(2'b10);
        send_challenge(32'h0, 1'b0, 1'b0);
        send_resp(0, N-1, -1, 0);
        wait_done(0, 2'b10);

        // Second transaction: throttled tx_ready, spurious start/rx/key during SEND.
        q_res.push_back(2'b10);
        send_challenge(32'h1234_5678, 1'b1, 1'b1);
        send_resp(0, N-1, -1, 1);
        wait_done(0, 2'b10);

        // Corrupted third byte.
        q_res.push_back(2'b00);
        send_challenge(32'hDEAD_BEEF, 1'b0, 1'b0);
        send_resp(0, N-1, 2, 0);
        wait_done(0, 2'b00);

        // No response at all.
        q_res.push_back(2'b01);
        send_challenge(32'hCAFE_F00D, 1'b0, 1'b0);
        wait_done(TO, 2'b01);

        // Every byte lands on the cycle the idle count would expire.
        q_res.push_back(2'b10);
        send_challenge(32'h0BAD_CAFE, 1'b1, 1'b0);
        send_resp(0, N-1, -1, TO - 1);
        wait_done(0, 2'b10);

        // Reset after two response bytes: no done, LFSR back to its seed.
        send_challenge(32'h5555_AAAA, 1'b0, 1'b0);
        send_resp(0, 1, -1, 0);
        d = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset();
        q_tx.delete();
        m_lfsr = 8'hA5;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("no_done_on_reset", 32'(done_cnt), 32'(d));

        q_res.push_back(2'b10);
        send_challenge(32'h0, 1'b0, 1'b0);
        send_resp(0, N-1, -1, 0);
        wait_done(0, 2'b10);

        check_eq("done_total", 32'(done_cnt), 32'd6);
        check_eq("tx_queue_drained", 32'(q_tx.size()), 32'd0);
        check_eq("res_queue_drained", 32'(q_res.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
